// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ writeback sources.
// Optional read-port forwarding of the in-flight write is enabled by defining WB_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hold,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [5*N_REQ-1:0]    req_num,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [4:0]            wr_num,
    output logic [31:0]           wr_data,
    output logic                  wr_en,
    output logic [CNT_W-1:0]      conflict_cnt
`ifdef WB_ARB_BYPASS_EN
    ,
    input  logic [4:0]            rd0_num,
    input  logic [4:0]            rd1_num,
    input  logic [31:0]           rd0_rf_data,
    input  logic [31:0]           rd1_rf_data,
    output logic [31:0]           rd0_data,
    output logic [31:0]           rd1_data
`endif
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  cand;
    logic              gnt_any;
    logic              multi_req;
    logic [REG_W-1:0]  num_a  [N_REQ];
    logic [DATA_W-1:0] data_a [N_REQ];

    // Unpack the flat request buses into per-requester arrays.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign num_a[i]  = req_num[REG_W*i +: REG_W];
        assign data_a[i] = req_data[DATA_W*i +: DATA_W];
    end

    // First valid requester at or after rr_ptr wins; hold suppresses all grants.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        if (!hold) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = PTR_W'((32'(rr_ptr) + k) % N_REQ);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) begin
                req_ready[gnt_idx] = 1'b1;
            end
        end
    end

    assign multi_req = !hold && ($countones(req_valid) > 1);

    // Pointer, registered write stage and saturating contention counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            wr_en        <= 1'b0;
            wr_num       <= '0;
            wr_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            wr_en <= gnt_any && (num_a[gnt_idx] != '0);
            if (gnt_any) begin
                rr_ptr  <= (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                wr_num  <= num_a[gnt_idx];
                wr_data <= data_a[gnt_idx];
            end
            if (multi_req && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

`ifdef WB_ARB_BYPASS_EN
    // Forward the registered write that has not yet landed in the regfile.
    assign rd0_data = (wr_en && (rd0_num == wr_num) && (rd0_num != '0)) ? wr_data : rd0_rf_data;
    assign rd1_data = (wr_en && (rd1_num == wr_num) && (rd1_num != '0)) ? wr_data : rd1_rf_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset_n;
    logic          hold;
    logic [N-1:0]  req_valid;
    logic [5*N-1:0]  req_num;
    logic [32*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [4:0]    wr_num;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic [CW-1:0] conflict_cnt;
`ifdef WB_ARB_BYPASS_EN
    logic [4:0]    rd0_num, rd1_num;
    logic [31:0]   rd0_rf_data, rd1_rf_data, rd0_data, rd1_data;
`endif

    regfile_wb_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_num      (req_num),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wr_num       (wr_num),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .conflict_cnt (conflict_cnt)
`ifdef WB_ARB_BYPASS_EN
        ,
        .rd0_num      (rd0_num),
        .rd1_num      (rd1_num),
        .rd0_rf_data  (rd0_rf_data),
        .rd1_rf_data  (rd1_rf_data),
        .rd0_data     (rd0_data),
        .rd1_data     (rd1_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        logic [4:0]  n0, n1, n2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic        en;
        logic [4:0]  num;
        logic [31:0] data;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl [17];
    int   passed = 0;
    int   total  = 0;

    // Reference model state
    int          m_ptr;
    int          m_cnt;
    logic        m_en;
    logic [4:0]  m_num;
    logic [31:0] m_data;

    function automatic vec_t mk(input logic h, input logic [2:0] v,
                                input logic [4:0] n0, input logic [4:0] n1, input logic [4:0] n2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] rdy, input logic en, input logic [4:0] num,
                                input logic [31:0] data, input logic [3:0] cnt);
        vec_t r;
        r.hold = h; r.valid = v;
        r.n0 = n0; r.n1 = n1; r.n2 = n2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.rdy = rdy; r.en = en; r.num = num; r.data = data; r.cnt = cnt;
        return r;
    endfunction

    // Round-robin choice from the rules: first valid index starting at ptr, or -1.
    function automatic int pick(input int ptr, input logic h, input logic [2:0] v);
        if (h) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic drive(input logic h, input logic [2:0] v,
                         input logic [4:0] n0, input logic [4:0] n1, input logic [4:0] n2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        hold      = h;
        req_valid = v;
        req_num   = {n2, n1, n0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.hold, v.valid, v.n0, v.n1, v.n2, v.d0, v.d1, v.d2);
        #1;
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'(v.rdy));
        @(posedge clk); #1;
        chk($sformatf("v%0d_wr_en", idx), 32'(wr_en), 32'(v.en));
        chk($sformatf("v%0d_wr_num", idx), 32'(wr_num), 32'(v.num));
        chk($sformatf("v%0d_wr_data", idx), wr_data, v.data);
        chk($sformatf("v%0d_cnt", idx), 32'(conflict_cnt), 32'(v.cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Directed sequence starting from reset
        tbl[0]  = mk(0, 3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1, 1, 32'hA0, 1);
        tbl[1]  = mk(0, 3'b110, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1, 2, 32'hA1, 2);
        tbl[2]  = mk(0, 3'b100, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1, 3, 32'hA2, 2);
        tbl[3]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3, 32'hA2, 2);
        tbl[4]  = mk(0, 3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 3'b010, 1, 5, 32'hDEADBEEF, 2);
        tbl[5]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5, 32'hDEADBEEF, 2);
        tbl[6]  = mk(0, 3'b001, 0, 0, 0, 32'h55, 0, 0, 3'b001, 0, 0, 32'h55, 2);
        for (int i = 7; i <= 10; i++)
            tbl[i] = mk(1, 3'b100, 0, 0, 9, 0, 0, 32'h99, 3'b000, 0, 0, 32'h55, 2);
        tbl[11] = mk(0, 3'b100, 0, 0, 9, 0, 0, 32'h99, 3'b100, 1, 9, 32'h99, 2);
        tbl[12] = mk(1, 3'b111, 1, 2, 3, 1, 2, 3, 3'b000, 0, 9, 32'h99, 2);
        tbl[13] = mk(0, 3'b101, 4, 0, 4, 32'hB0, 0, 32'hB2, 3'b001, 1, 4, 32'hB0, 3);
        tbl[14] = mk(0, 3'b100, 4, 0, 4, 32'hB0, 0, 32'hB2, 3'b100, 1, 4, 32'hB2, 3);
        tbl[15] = mk(0, 3'b010, 0, 6, 0, 0, 32'hC1, 0, 3'b010, 1, 6, 32'hC1, 3);
        tbl[16] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 6, 32'hC1, 3);

        reset_n = 1'b0;
        drive(0, 3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2);
`ifdef WB_ARB_BYPASS_EN
        rd0_num = '0; rd1_num = '0; rd0_rf_data = '0; rd1_rf_data = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_cnt", 32'(conflict_cnt), 0);
        chk("rst_wr_num", 32'(wr_num), 0);
        chk("rst_wr_data", wr_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

`ifdef WB_ARB_BYPASS_EN
        // Forwarding of r7 while its write is in flight; r0 never forwards
        drive(0, 3'b001, 7, 0, 0, 32'h1234, 0, 0);
        rd0_num = 5'd7; rd0_rf_data = 32'h0;
        rd1_num = 5'd0; rd1_rf_data = 32'hCAFE;
        #1;
        chk("byp_before", rd0_data, 32'h0);
        chk("byp_r0_pass", rd1_data, 32'hCAFE);
        @(posedge clk); #1;
        chk("byp_fwd", rd0_data, 32'h1234);
        chk("byp_r0_hold", rd1_data, 32'hCAFE);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("byp_after", rd0_data, 32'h0);
`endif

        // Reset in the cycle a registered write is on the port
        drive(0, 3'b010, 0, 8, 0, 0, 32'h77, 0);
        #1;
        chk("mid_ready", 32'(req_ready), 32'b010);
        @(posedge clk); #1;
        chk("mid_wr_en_pre", 32'(wr_en), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_wr_en_drop", 32'(wr_en), 0);
        chk("mid_wr_num", 32'(wr_num), 0);
        chk("mid_wr_data", wr_data, 0);
        chk("mid_cnt", 32'(conflict_cnt), 0);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_pulse", 32'(wr_en), 0);

        m_ptr = 0; m_cnt = 0; m_en = 0; m_num = '0; m_data = '0;

        // Randomized traffic against the model
        for (int c = 0; c < 300; c++) begin
            logic        h;
            logic [2:0]  v;
            logic [4:0]  n [3];
            logic [31:0] d [3];
            int          g;
            h = ($urandom_range(3) == 0);
            v = 3'($urandom);
            for (int j = 0; j < 3; j++) begin
                n[j] = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom);
                d[j] = $urandom;
            end
            drive(h, v, n[0], n[1], n[2], d[0], d[1], d[2]);
`ifdef WB_ARB_BYPASS_EN
            rd0_num = ($urandom_range(1) == 0) ? m_num : 5'($urandom);
            rd0_rf_data = $urandom;
`endif
            g = pick(m_ptr, h, v);
            #1;
            chk("rand_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) begin
                m_en   = (n[g] != 5'd0);
                m_num  = n[g];
                m_data = d[g];
                m_ptr  = (g + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            if (!h && ($countones(v) >= 2) && (m_cnt < CNT_MAX)) m_cnt++;
            @(posedge clk); #1;
            chk("rand_wr_en", 32'(wr_en), 32'(m_en));
            chk("rand_wr_num", 32'(wr_num), 32'(m_num));
            chk("rand_wr_data", wr_data, m_data);
            chk("rand_cnt", 32'(conflict_cnt), 32'(m_cnt));
`ifdef WB_ARB_BYPASS_EN
            chk("rand_byp", rd0_data,
                (m_en && (rd0_num == m_num) && (rd0_num != 5'd0)) ? m_data : rd0_rf_data);
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
